// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_pkg
// Description : Shared state encoding and defaults for the config loaders.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_pkg;

    localparam int C_DEFAULT_NUM_REGS = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // A frame is in flight in exactly these states.
    function automatic logic is_busy(input state_t s);
        return (s == ST_HEADER) || (s == ST_LOAD) || (s == ST_CHECK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : cfg_onehot_dec
// Description : Index to one-hot decoder with enable, for register bank strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_onehot_dec
    import cfg_pkg::*;
#(
    parameter int NUM_REGS = C_DEFAULT_NUM_REGS,
    parameter int ADDR_W   = 4
) (
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot
);

    genvar i;
    for (i = 0; i < NUM_REGS; i++) begin : g_bit
        assign onehot[i] = en && (addr == ADDR_W'(i));
    end

endmodule
`default_nettype wire

// File: rtl/cfg_reg_loader.sv
`default_nettype none
// ============================================================================
// Module      : cfg_reg_loader
// Description : Fills a bank of 8-bit config registers from a checked byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_reg_loader
    import cfg_pkg::*;
#(
    parameter int NUM_REGS = C_DEFAULT_NUM_REGS,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic [7:0]          reg_data,
    output logic [NUM_REGS-1:0] reg_ld,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     loaded_count
);

    // Wide enough to hold both a header byte and NUM_REGS (up to 256).
    localparam int C_CMP_W = 9;

    state_t              state_q, state_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          reg_data_q, reg_data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [NUM_REGS-1:0] reg_ld_q, reg_ld_d;
    logic [ADDR_W:0]     w_cnt_inc;
    logic                w_accept;
    logic                w_load_en;
    logic                w_hdr_bad;

    assign busy       = is_busy(state_q);
    assign byte_ready = busy & ~abort;
    assign w_accept   = byte_valid & byte_ready;
    assign w_cnt_inc  = cnt_q + (ADDR_W+1)'(1);
    assign w_hdr_bad  = (byte_in == 8'd0) ||
                        (C_CMP_W'(byte_in) > C_CMP_W'(NUM_REGS));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        csum_d     = csum_q;
        cnt_d      = cnt_q;
        reg_data_d = reg_data_q;
        w_load_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (state_q == ST_DONE) state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_HEADER;
                    addr_d  = '0;
                    csum_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_HEADER: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (w_accept) begin
                    len_d   = byte_in;
                    state_d = w_hdr_bad ? ST_ERROR : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (w_accept) begin
                    reg_data_d = byte_in;
                    w_load_en  = 1'b1;
                    csum_d     = csum_q ^ byte_in;
                    addr_d     = addr_q + ADDR_W'(1);
                    cnt_d      = w_cnt_inc;
                    if (C_CMP_W'(w_cnt_inc) == C_CMP_W'(len_q)) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (w_accept) begin
                    state_d = (byte_in == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobe is registered from the pre-increment address of the accepting edge.
    cfg_onehot_dec #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_dec (
        .en     (w_load_en),
        .addr   (addr_q),
        .onehot (reg_ld_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            csum_q     <= '0;
            cnt_q      <= '0;
            reg_data_q <= '0;
            reg_ld_q   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            csum_q     <= csum_d;
            cnt_q      <= cnt_d;
            reg_data_q <= reg_data_d;
            reg_ld_q   <= reg_ld_d;
        end
    end

    assign reg_data     = reg_data_q;
    assign reg_ld       = reg_ld_q;
    assign loaded_count = cnt_q;
    assign done         = (state_q == ST_DONE);
    assign err          = (state_q == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_cfg_reg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_reg_loader
// Description : Randomized self-checking bench with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_reg_loader;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    byte_in = 8'd0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [7:0]    reg_data;
    logic [N-1:0]  reg_ld;
    logic          busy;
    logic          done;
    logic          err;
    logic [4:0]    loaded_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Frame-progress model: pos 0 = header due, 1..len = data, len+1 = checksum.
    bit m_in_frame = 1'b0;
    int m_pos = 0, m_len = 0, m_csum = 0, m_count = 0, m_data = 0, m_ld = -1;
    bit m_done = 1'b0, m_err = 1'b0;

    cfg_reg_loader #(.NUM_REGS(N), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .reg_data     (reg_data),
        .reg_ld       (reg_ld),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .loaded_count (loaded_count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_ld();
        return (m_ld >= 0) ? (32'd1 << m_ld) : 32'd0;
    endfunction

    always @(negedge clk) begin
        #2;
        if (chk_on) begin
            cmp("busy",         busy,         m_in_frame);
            cmp("byte_ready",   byte_ready,   m_in_frame && !abort);
            cmp("done",         done,         m_done);
            cmp("err",          err,          m_err);
            cmp("reg_ld",       reg_ld,       exp_ld());
            cmp("reg_data",     reg_data,     m_data);
            cmp("loaded_count", loaded_count, m_count);
        end
    end

    // One clock: drive inputs, advance the model by the frame rules, settle.
    task automatic step(input bit s, input bit a, input bit v, input logic [7:0] b,
                        input bit r = 1'b1);
        bit f, dn, er;
        int pos, len, cs, cnt, dat, ld;
        @(negedge clk);
        rst = r; start = s; abort = a; byte_valid = v; byte_in = b;
        f = m_in_frame; pos = m_pos; len = m_len; cs = m_csum; cnt = m_count;
        dat = m_data; ld = -1; dn = 1'b0; er = m_err;
        if (!r) begin
            f = 1'b0; pos = 0; len = 0; cs = 0; cnt = 0; dat = 0; er = 1'b0;
        end else if (!f) begin
            if (s) begin f = 1'b1; pos = 0; cs = 0; cnt = 0; er = 1'b0; end
        end else if (a) begin
            f = 1'b0;
        end else if (v) begin
            if (pos == 0) begin
                len = int'(b);
                if (len == 0 || len > N) begin f = 1'b0; er = 1'b1; end
                else pos = 1;
            end else if (pos <= len) begin
                dat = int'(b); ld = pos - 1; cs = cs ^ int'(b); cnt++; pos++;
            end else begin
                f = 1'b0;
                if (int'(b) == cs) dn = 1'b1; else er = 1'b1;
            end
        end
        @(posedge clk);
        m_in_frame = f; m_pos = pos; m_len = len; m_csum = cs; m_count = cnt;
        m_data = dat; m_ld = ld; m_done = dn; m_err = er;
        #1;
    endtask

    // Present one byte, optionally with random valid gaps and start noise.
    task automatic send(input logic [7:0] b, input bit gaps);
        bit v;
        int tries;
        tries = 0;
        do begin
            v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (tries > 20) v = 1'b1;
            step(gaps && ($urandom_range(0, 3) == 0), 1'b0, v, v ? b : 8'($urandom));
            tries++;
        end while (!v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes [16];
        logic [7:0] cs8;
        int flen, sel, abort_at, gap;
        bit bad;

        // Reset
        step(0, 0, 0, 8'h00, 0);
        chk_on = 1'b1;
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00);
        cmp("rst_busy", busy, 0);
        cmp("rst_ld", reg_ld, 0);
        cmp("rst_count", loaded_count, 0);

        // Nominal frame: 03 A5 3C 0F, checksum 96
        step(1, 0, 0, 8'h00);
        cmp("nom_busy", busy, 1);
        send(8'h03, 0);
        send(8'hA5, 0); cmp("nom_ld0", reg_ld, 16'h0001); cmp("nom_d0", reg_data, 8'hA5);
        send(8'h3C, 0); cmp("nom_ld1", reg_ld, 16'h0002); cmp("nom_d1", reg_data, 8'h3C);
        send(8'h0F, 0); cmp("nom_ld2", reg_ld, 16'h0004); cmp("nom_d2", reg_data, 8'h0F);
        send(8'h96, 0);
        cmp("nom_done", done, 1); cmp("nom_count", loaded_count, 3); cmp("nom_err", err, 0);
        step(0, 0, 0, 8'h00);
        cmp("nom_done_pulse", done, 0);

        // Bad checksum: 02 11 22, checksum 00 (true checksum 33)
        step(1, 0, 0, 8'h00);
        send(8'h02, 0); send(8'h11, 0); send(8'h22, 0); send(8'h00, 0);
        cmp("badcs_err", err, 1);
        step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
        cmp("badcs_err_held", err, 1); cmp("badcs_done", done, 0);

        // Bad headers: 00, then 11 (17 > 16); start with abort in the same cycle
        step(1, 0, 0, 8'h00);
        cmp("hdr_start_clr", err, 0);
        send(8'h00, 0);
        cmp("hdr0_err", err, 1); cmp("hdr0_ld", reg_ld, 0);
        step(1, 1, 0, 8'h00);
        cmp("hdr_start_wins", busy, 1);
        send(8'h11, 0);
        cmp("hdr17_err", err, 1); cmp("hdr17_ld", reg_ld, 0);
        step(1, 0, 0, 8'h00);
        cmp("hdr_clr_err", err, 0);
        step(0, 1, 0, 8'h00);

        // Backpressure: 16-byte frame with random valid gaps
        cs8 = 8'h00;
        for (int i = 0; i < 16; i++) begin bytes[i] = 8'($urandom); cs8 ^= bytes[i]; end
        step(1, 0, 0, 8'h00);
        send(8'h10, 1);
        for (int i = 0; i < 16; i++) begin
            send(bytes[i], 1);
            cmp("bp_ld", reg_ld, 32'd1 << i);
        end
        send(cs8, 1);
        cmp("bp_done", done, 1); cmp("bp_count", loaded_count, 16);
        step(0, 0, 0, 8'h00);

        // Abort on byte 2 of a 4-byte frame
        step(1, 0, 0, 8'h00);
        send(8'h04, 0); send(8'hA1, 0);
        cmp("abort_ld0", reg_ld, 16'h0001);
        step(0, 1, 1, 8'hA2);
        cmp("abort_busy", busy, 0); cmp("abort_err", err, 0);
        cmp("abort_count", loaded_count, 1); cmp("abort_ld", reg_ld, 0);

        // Reset on the edge after a LOAD handshake drops the pending strobe
        step(1, 0, 0, 8'h00);
        send(8'h03, 0); send(8'hB1, 0);
        step(0, 0, 0, 8'h00, 0);
        cmp("mrst_ld", reg_ld, 0); cmp("mrst_busy", busy, 0);
        cmp("mrst_count", loaded_count, 0); cmp("mrst_data", reg_data, 0);

        // Random frames: good, bad checksum, bad header, aborted
        for (int k = 0; k < 40; k++) begin
            sel  = $urandom_range(0, 9);
            flen = $urandom_range(1, 16);
            if (sel == 0) flen = 0;
            if (sel == 1) flen = $urandom_range(17, 255);
            bad      = ($urandom_range(0, 4) == 0);
            abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 17) : -1;
            cs8 = 8'h00;
            step(1, $urandom_range(0, 1) == 1, 0, 8'h00);
            for (int p = 0; p <= 17; p++) begin
                if (p == abort_at) begin
                    step(0, 1, $urandom_range(0, 1) == 1, 8'($urandom));
                    break;
                end
                if (p == 0) begin
                    send(8'(flen), 1);
                    if (flen == 0 || flen > 16) break;
                end else if (p <= flen) begin
                    bytes[0] = 8'($urandom);
                    cs8 ^= bytes[0];
                    send(bytes[0], 1);
                end else begin
                    send(bad ? ~cs8 : cs8, 1);
                    break;
                end
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step(0, 0, 0, 8'($urandom));
        end

        step(0, 0, 0, 8'h00);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
